// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier.
// Loads M, Q, A=0 and Q(-1)=0 when an operand pair is accepted. Each RUN cycle
// then adds or subtracts M based on {Q[0],Q(-1)} and arithmetic-shifts
// {A,Q,Q(-1)} right by one. After WIDTH iterations the result {A[WIDTH-1:0],Q}
// is held in DONE until the consumer takes it.
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    // The counter must be able to hold the value WIDTH itself.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [WIDTH:0]    a_reg, a_next;       // accumulator, one guard bit
    logic [WIDTH:0]    m_reg, m_next;       // sign-extended multiplicand
    logic [WIDTH-1:0]  q_reg, q_next;
    logic              qm1_reg, qm1_next;   // Q(-1)
    logic [CW-1:0]     count_reg, count_next;

    logic [WIDTH:0]    t_sum;               // add/sub result, before the shift
    logic [WIDTH-1:0]  q_shift;             // Q after the right shift

    // Booth recoding: choose A+M, A-M or A from {Q[0],Q(-1)}.
    // The WIDTH+1 bit width lets M = -2^(WIDTH-1) be negated without overflow.
    always_comb begin
        t_sum = a_reg;
        case ({q_reg[0], qm1_reg})
            2'b01:   t_sum = a_reg + m_reg;
            2'b10:   t_sum = a_reg - m_reg;
            default: t_sum = a_reg;
        endcase
    end

    // Q shifts right one bit per iteration, and the low bit of T enters at the top.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_qshift
            assign q_shift[gi] = q_reg[gi + 1];
        end
    endgenerate
    assign q_shift[WIDTH-1] = t_sum[0];

    // Next-state and datapath update. By default every register holds its value.
    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        m_next     = m_reg;
        q_next     = q_reg;
        qm1_next   = qm1_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    m_next     = {multiplicand[WIDTH-1], multiplicand};
                    q_next     = multiplier;
                    a_next     = '0;
                    qm1_next   = 1'b0;
                    count_next = CW'(WIDTH);
                    state_next = RUN;
                end
            end
            RUN: begin
                a_next     = {t_sum[WIDTH], t_sum[WIDTH:1]};
                q_next     = q_shift;
                qm1_next   = q_reg[0];
                count_next = count_reg - CW'(1);
                if (count_reg == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers. Reset is asynchronous and active low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            m_reg     <= '0;
            q_reg     <= '0;
            qm1_reg   <= 1'b0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            m_reg     <= m_next;
            q_reg     <= q_next;
            qm1_reg   <= qm1_next;
            count_reg <= count_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg == RUN);
    assign out_valid = (state_reg == DONE);
    assign product   = {a_reg[WIDTH-1:0], q_reg};

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and random checks for booth_mult_seq with WIDTH=8.
module tb_booth_mult_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_ready;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;

    int n_checks = 0;
    int n_pass   = 0;

    booth_mult_seq #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One multiply: accept, wait for out_valid, check latency/product, hold for
    // 'gap' cycles of back-pressure, then transfer. 'poke' pulses start during
    // RUN and DONE with junk operands, which must be ignored.
    task automatic run_mult(input string name, input logic [7:0] a, input logic [7:0] b,
                            input logic [15:0] exp, input int gap, input bit poke);
        int lat;
        int busy_cnt;
        int waited;
        bit hold_ok;
        waited = 0;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        check({name, " in_ready_before"}, 32'(in_ready), 32'd1);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        out_ready    = (gap == 0);
        tick();                                   // accept edge
        start        = 1'b0;
        multiplicand = 8'($urandom);
        multiplier   = 8'($urandom);
        check({name, " in_ready_after_accept"}, 32'(in_ready), 32'd0);
        lat      = 1;
        busy_cnt = 0;
        while (!out_valid && lat < 40) begin
            busy_cnt += int'(busy);
            if (poke && busy_cnt == 3) start = 1'b1;
            tick();
            start = 1'b0;
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'd9);
        check({name, " busy_cycles"}, 32'(busy_cnt), 32'd8);
        check({name, " product"}, 32'(product), 32'(exp));
        hold_ok = 1'b1;
        for (int i = 0; i < gap; i++) begin
            if (poke && i == 5) begin
                start        = 1'b1;
                multiplicand = 8'h11;
                multiplier   = 8'h22;
            end
            tick();
            start = 1'b0;
            if (product !== exp || out_valid !== 1'b1 || busy !== 1'b0) hold_ok = 1'b0;
        end
        if (gap > 0) check({name, " hold"}, 32'(hold_ok), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, " valid_drop"}, 32'(out_valid), 32'd0);
        check({name, " idle_after"}, {30'd0, in_ready, busy}, 32'b10);
        $display("txn %s a=%h b=%h product=%h exp=%h lat=%0d gap=%0d", name, a, b, product, exp, lat, gap);
    endtask

    initial begin
        logic signed [7:0] sa;
        logic signed [7:0] sb;
        logic [15:0] e;
        int p;
        bit quiet;

        rst_n        = 1'b0;
        start        = 1'b0;
        out_ready    = 1'b0;
        multiplicand = 8'h00;
        multiplier   = 8'h00;
        #1;
        check("reset_outputs", {14'd0, in_ready, busy, out_valid, product}, {14'd0, 1'b1, 1'b0, 1'b0, 16'h0000});
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // Directed vectors with hand-computed products.
        run_mult("3x5",        8'd3,   8'd5,   16'h000F, 0, 1'b0);
        run_mult("m7x3",       8'hF9,  8'd3,   16'hFFEB, 0, 1'b0);
        run_mult("3xm7",       8'd3,   8'hF9,  16'hFFEB, 2, 1'b0);
        run_mult("m128xm128",  8'h80,  8'h80,  16'h4000, 0, 1'b0);
        run_mult("127xm128",   8'h7F,  8'h80,  16'hC080, 1, 1'b0);
        run_mult("0xm128",     8'h00,  8'h80,  16'h0000, 0, 1'b0);
        run_mult("m1xm1",      8'hFF,  8'hFF,  16'h0001, 0, 1'b0);
        run_mult("backpress",  8'd12,  8'hF6,  16'hFF88, 20, 1'b1);

        // Asynchronous reset in the middle of the fourth iteration.
        multiplicand = 8'd9;
        multiplier   = 8'd7;
        start        = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        #3 rst_n = 1'b0;
        #1;
        check("midrun_reset_outputs", {14'd0, in_ready, busy, out_valid, product}, {14'd0, 1'b1, 1'b0, 1'b0, 16'h0000});
        quiet = 1'b1;
        repeat (2) begin
            tick();
            if (out_valid !== 1'b0 || product !== 16'h0000) quiet = 1'b0;
        end
        #3 rst_n = 1'b1;
        repeat (12) begin
            tick();
            if (out_valid !== 1'b0 || in_ready !== 1'b1) quiet = 1'b0;
        end
        check("midrun_no_valid", 32'(quiet), 32'd1);
        $display("txn midrun_reset a=09 b=07 aborted");
        run_mult("2x2", 8'd2, 8'd2, 16'h0004, 0, 1'b0);

        // Random back-to-back sweep against a signed reference product.
        for (int k = 0; k < 1000; k++) begin
            sa = 8'($urandom);
            sb = 8'($urandom);
            p  = int'(sa) * int'(sb);
            e  = p[15:0];
            run_mult("rand", sa, sb, e, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
